seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: digit count, legal range 2..8.
REQ-002 Parameter TICK_DIV, default 50000: clk50MHz cycles per digit slot (1 kHz digit rate).
REQ-003 Parameter GUARD_CYCLES, default 500: blanked cycles at the start of each slot; SHALL satisfy 1 <= GUARD_CYCLES < TICK_DIV.
REQ-004 clk50MHz  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 load  input  1  one-cycle strobe; captures digits_in and dp_in.
REQ-007 digits_in  input  4*NUM_DIGITS  BCD nibbles; digit 0 in bits [3:0].
REQ-008 dp_in  input  NUM_DIGITS  decimal-point request per digit, 1 = lit.
REQ-009 LEDSEL  output  NUM_DIGITS  digit enables, active-low, at most one bit low.
REQ-010 LEDOUT  output  8  segment pattern, active-low; bit 7 = DP.
REQ-011 update_pending  output  1  captured data not yet displayed.
REQ-012 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 Prescaler SHALL count 0..TICK_DIV-1 and wrap; slot index SHALL advance on wrap, NUM_DIGITS-1 -> 0.
REQ-014 Frame boundary = cycle where prescaler = TICK_DIV-1 and index = NUM_DIGITS-1.
REQ-015 Decode: 0=88,1=ED,2=A2,3=A4,4=C5,5=94,6=90,7=AD,8=80,9=84 (hex); nibbles A-F -> FF.
REQ-016 DP: when the digit's dp bit is 1, LEDOUT[7] SHALL be 0; otherwise as decoded.
REQ-017 Guard: while prescaler < GUARD_CYCLES, LEDSEL SHALL be all ones and LEDOUT 8'hFF.
REQ-018 Else LEDSEL bit [index] SHALL be 0, others 1; LEDOUT = decoded display digit [index].
REQ-019 LEDSEL/LEDOUT SHALL be registered: one cycle latency after prescaler/index state.
REQ-020 load SHALL write pending register (digits, dp) and set update_pending next cycle; a later load before transfer overwrites (latest wins).
REQ-021 At frame boundary with pending set, display register <- pending, update_pending cleared next cycle.
REQ-022 load on a boundary cycle: old pending (if any) transfers; new data is held pending until the following boundary.
REQ-023 frame_done SHALL be high for exactly the cycle after each boundary, every TICK_DIV*NUM_DIGITS cycles.
REQ-024 Display register SHALL change only at frame boundaries (no tearing).

Reset
REQ-025 rst SHALL set prescaler 0, index 0, display digits 4'hF, display dp 0, pending cleared, update_pending 0.
REQ-026 Outputs during and the cycle after rst: LEDSEL all ones, LEDOUT 8'hFF, frame_done 0.
REQ-027 rst mid-frame SHALL discard pending data; load coincident with rst SHALL be ignored.
REQ-028 After rst release, first slot SHALL be index 0 starting at prescaler 0.

Configuration
REQ-029 Macro SEG_SCAN_LZB_EN defined: leading-zero blanking -- zero digits above the highest nonzero digit SHALL show segments blank (LEDOUT[6:0]=7'h7F); digit 0 always shown; DP unaffected.
REQ-030 Macro undefined: every zero digit SHALL display 8'h88 (DP rules per REQ-016).

Verification (NUM_DIGITS=4, TICK_DIV=8, GUARD_CYCLES=2)
REQ-031 Assert rst 3 cycles -> LEDSEL=4'hF, LEDOUT=8'hFF, update_pending=0, frame_done=0; then slot 0 active segments 8'hFF (blank digits).
REQ-032 load 16'h1234 mid-frame -> update_pending=1 until next boundary; next frame slot 0: 2 cycles 4'hF/FF, then 6 cycles 4'b1110/8'hC5; slot 3 shows 4'b0111/8'hED.
REQ-033 load 16'h5678 on boundary cycle -> current frame shows previous data; 5678 appears one frame (32 cycles) later; frame_done pulses every 32 cycles.
REQ-034 load 16'h1111 then 16'h9999 within one frame, dp_in=4'b0001 -> all slots 8'h84 except slot 0 = 8'h04.
REQ-035 load 16'h0070: with SEG_SCAN_LZB_EN slots 3,2 = 8'hFF, slot 1 = 8'hAD, slot 0 = 8'h88; without: 88,88,AD,88.
REQ-036 load then rst before boundary -> update_pending=0, display stays blank (8'hFF) through following frames.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
`timescale 1ns/1ps
// seg_scan_ctrl: multiplexed 7-segment scanner with guard blanking and frame-synchronous display update.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk50MHz,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   LEDSEL,
  output logic [7:0]              LEDOUT,
  output logic                    update_pending,
  output logic                    frame_done
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] GUARD   = CW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]              cnt;
  logic [IW-1:0]              idx;
  logic [NUM_DIGITS-1:0][3:0] pend_dig, disp_dig;
  logic [NUM_DIGITS-1:0]      pend_dp, disp_dp;
  logic [NUM_DIGITS-1:0]      blank;
  logic                       boundary;
  logic [3:0]                 cur_dig;
  logic [7:0]                 cur_seg;

  assign boundary = (cnt == CNT_MAX) && (idx == IDX_MAX);

  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Pending data moves to the display only on a frame boundary; a load on that
  // same cycle lands in pending and waits for the next boundary.
  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      pend_dig       <= '0;
      pend_dp        <= '0;
      update_pending <= 1'b0;
      disp_dig       <= {NUM_DIGITS{4'hF}};
      disp_dp        <= '0;
    end else begin
      if (boundary && update_pending) begin
        disp_dig <= pend_dig;
        disp_dp  <= pend_dp;
      end
      if (load) begin
        pend_dig       <= digits_in;
        pend_dp        <= dp_in;
        update_pending <= 1'b1;
      end else if (boundary) begin
        update_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    logic seen;
    seen  = 1'b0;
    blank = '0;
`ifdef SEG_SCAN_LZB_EN
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      seen     = seen | (disp_dig[i] != 4'h0);
      blank[i] = ~seen;
    end
`else
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      seen     = seen | (disp_dig[i] != 4'h0);
      blank[i] = 1'b0;
    end
`endif
  end

  assign cur_dig = disp_dig[idx];

  always_comb begin
    case (cur_dig)
      4'd0:    cur_seg = 8'h88;
      4'd1:    cur_seg = 8'hED;
      4'd2:    cur_seg = 8'hA2;
      4'd3:    cur_seg = 8'hA4;
      4'd4:    cur_seg = 8'hC5;
      4'd5:    cur_seg = 8'h94;
      4'd6:    cur_seg = 8'h90;
      4'd7:    cur_seg = 8'hAD;
      4'd8:    cur_seg = 8'h80;
      4'd9:    cur_seg = 8'h84;
      default: cur_seg = 8'hFF;
    endcase
    if (blank[idx])   cur_seg[6:0] = 7'h7F;
    if (disp_dp[idx]) cur_seg[7]   = 1'b0;
  end

  // Registered outputs: the guard window blanks everything to avoid ghosting between digits.
  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      LEDSEL     <= '1;
      LEDOUT     <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (cnt < GUARD) begin
        LEDSEL <= '1;
        LEDOUT <= 8'hFF;
      end else begin
        LEDSEL <= ~(NUM_DIGITS'(1) << idx);
        LEDOUT <= cur_seg;
      end
    end
  end
endmodule
